// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter driving one asynchronous SRAM through IDLE/SETUP/STROBE/HOLD.
// Latency: req sampled in IDLE -> ack STROBE_CYCLES+2 cycles later; access period STROBE_CYCLES+3.
// Backpressure: req is a level held until ack; a loser simply keeps req high and is served next.
module sram_arbiter #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 12,
    parameter int STROBE_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_ack,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_ack,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    inout  wire  [DATA_WIDTH-1:0] sram_data,
    output logic                  sram_ce_n,
    output logic                  sram_we_n,
    output logic                  sram_oe_n,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    typedef struct packed {
        logic                  we;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);

    state_t     state;
    req_t       cur;
    logic [3:0] strobe_cnt;
    logic       last_grant;
    logic       drive_en;
    logic       grant_p1;

    // On a tie the port that was not served last wins; last_grant==1 means port 1.
    always_comb begin
        grant_p1 = p1_req;
        if (p0_req && p1_req) begin
            grant_p1 = !last_grant;
        end
    end

    assign sram_data = drive_en ? cur.wdata : {DATA_WIDTH{1'bz}};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cur        <= '0;
            strobe_cnt <= '0;
            last_grant <= 1'b1;
            drive_en   <= 1'b0;
            sram_addr  <= '0;
            sram_ce_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            busy       <= 1'b0;
            p0_ack     <= 1'b0;
            p1_ack     <= 1'b0;
            p0_rdata   <= '0;
            p1_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (p0_req || p1_req) begin
                        last_grant <= grant_p1;
                        cur.we     <= grant_p1 ? p1_we : p0_we;
                        cur.wdata  <= grant_p1 ? p1_wdata : p0_wdata;
                        sram_addr  <= grant_p1 ? p1_addr : p0_addr;
                        drive_en   <= grant_p1 ? p1_we : p0_we;
                        sram_ce_n  <= 1'b0;
                        busy       <= 1'b1;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    strobe_cnt <= STROBE_LAST;
                    sram_we_n  <= !cur.we;
                    sram_oe_n  <= cur.we;
                    state      <= STROBE;
                end
                STROBE: begin
                    if (strobe_cnt == 4'd0) begin
                        sram_we_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        p0_ack    <= !last_grant;
                        p1_ack    <= last_grant;
                        if (!cur.we && !last_grant) begin
                            p0_rdata <= sram_data;
                        end
                        if (!cur.we && last_grant) begin
                            p1_rdata <= sram_data;
                        end
                        state <= HOLD;
                    end else begin
                        strobe_cnt <= strobe_cnt - 4'd1;
                    end
                end
                HOLD: begin
                    sram_ce_n <= 1'b1;
                    drive_en  <= 1'b0;
                    busy      <= 1'b0;
                    p0_ack    <= 1'b0;
                    p1_ack    <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench: two arbiter instances (STROBE_CYCLES 1 and 4), each on a behavioural async SRAM.
module tb_sram_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // instance A: STROBE_CYCLES=1, both ports
    logic        p0_req, p0_we, p1_req, p1_we, p0_ack, p1_ack;
    logic [11:0] p0_addr, p1_addr, a_addr;
    logic [7:0]  p0_wdata, p1_wdata, p0_rdata, p1_rdata;
    wire  [7:0]  a_data;
    logic        a_ce_n, a_we_n, a_oe_n, a_busy;
    logic [7:0]  mem_a [0:4095];

    sram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(12), .STROBE_CYCLES(1)) dut_a (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .sram_addr(a_addr), .sram_data(a_data),
        .sram_ce_n(a_ce_n), .sram_we_n(a_we_n), .sram_oe_n(a_oe_n), .busy(a_busy)
    );

    assign a_data = (!a_ce_n && !a_oe_n && a_we_n) ? mem_a[a_addr] : 8'bz;
    always @(posedge clk) if (!a_ce_n && !a_we_n) mem_a[a_addr] <= a_data;

    // instance B: STROBE_CYCLES=4, port 0 only
    logic        b_req, b_we, b_ack, b_p1_ack;
    logic [11:0] b_addr_in, b_addr;
    logic [7:0]  b_wdata, b_rdata, b_p1_rdata;
    wire  [7:0]  b_data;
    logic        b_ce_n, b_we_n, b_oe_n, b_busy;
    logic [7:0]  mem_b [0:4095];

    sram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(12), .STROBE_CYCLES(4)) dut_b (
        .clk(clk), .reset(reset),
        .p0_req(b_req), .p0_we(b_we), .p0_addr(b_addr_in), .p0_wdata(b_wdata),
        .p0_ack(b_ack), .p0_rdata(b_rdata),
        .p1_req(1'b0), .p1_we(1'b0), .p1_addr(12'h000), .p1_wdata(8'h00),
        .p1_ack(b_p1_ack), .p1_rdata(b_p1_rdata),
        .sram_addr(b_addr), .sram_data(b_data),
        .sram_ce_n(b_ce_n), .sram_we_n(b_we_n), .sram_oe_n(b_oe_n), .busy(b_busy)
    );

    assign b_data = (!b_ce_n && !b_oe_n && b_we_n) ? mem_b[b_addr] : 8'bz;
    always @(posedge clk) if (!b_ce_n && !b_we_n) mem_b[b_addr] <= b_data;

    // Bus-protocol monitors: strobe exclusivity, address/write-data stability over an access.
    logic        a_prev_ce_n = 1'b1, b_prev_ce_n = 1'b1;
    logic [11:0] a_cap_addr, b_cap_addr;
    logic [7:0]  a_cap_dat, b_cap_dat;

    always @(negedge clk) begin
        if (!reset) begin
            chk("a_we_oe_both_low", {31'd0, (!a_we_n && !a_oe_n)}, 32'd0);
            chk("b_we_oe_both_low", {31'd0, (!b_we_n && !b_oe_n)}, 32'd0);
            if (!a_ce_n && !a_prev_ce_n) begin
                chk("a_addr_stable", {20'd0, a_addr}, {20'd0, a_cap_addr});
                if (!a_we_n) chk("a_wdat_stable", {24'd0, a_data}, {24'd0, a_cap_dat});
            end
            if (!b_ce_n && !b_prev_ce_n) begin
                chk("b_addr_stable", {20'd0, b_addr}, {20'd0, b_cap_addr});
                if (!b_we_n) chk("b_wdat_stable", {24'd0, b_data}, {24'd0, b_cap_dat});
            end
        end
        if (!a_ce_n && a_prev_ce_n) begin
            a_cap_addr <= a_addr;
            a_cap_dat  <= a_data;
        end
        if (!b_ce_n && b_prev_ce_n) begin
            b_cap_addr <= b_addr;
            b_cap_dat  <= b_data;
        end
        a_prev_ce_n <= a_ce_n;
        b_prev_ce_n <= b_ce_n;
    end

    // Raise a request on a negedge, count negedges until ack is seen, drop req there.
    task automatic acc_a(input int port, input logic we, input logic [11:0] addr,
                         input logic [7:0] wd, output int lat);
        @(negedge clk);
        if (port == 0) begin
            p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wd;
        end else begin
            p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wd;
        end
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) chk("a_busy_during", {31'd0, a_busy}, 32'd1);
            if ((port == 0) ? p0_ack : p1_ack) begin
                lat = i;
                break;
            end
        end
        if (port == 0) p0_req = 1'b0;
        else p1_req = 1'b0;
        if (lat == 0) chk("a_ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic acc_b(input logic we, input logic [11:0] addr, input logic [7:0] wd,
                         output int lat, output int low);
        @(negedge clk);
        b_req = 1'b1; b_we = we; b_addr_in = addr; b_wdata = wd;
        lat = 0;
        low = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (!b_we_n || !b_oe_n) low++;
            if (b_ack) begin
                lat = i;
                break;
            end
        end
        b_req = 1'b0;
        if (lat == 0) chk("b_ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    int lat, low;
    int ack_port [4];
    int ack_cyc  [4];
    int nacks;
    int p0_seen, p1_seen;

    initial begin
        reset = 1'b1;
        {p0_req, p0_we, p1_req, p1_we, b_req, b_we} = '0;
        {p0_addr, p1_addr, b_addr_in} = '0;
        {p0_wdata, p1_wdata, b_wdata} = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ce_n",  {31'd0, a_ce_n}, 32'd1);
        chk("rst_we_n",  {31'd0, a_we_n}, 32'd1);
        chk("rst_oe_n",  {31'd0, a_oe_n}, 32'd1);
        chk("rst_busy",  {31'd0, a_busy}, 32'd0);
        chk("rst_acks",  {30'd0, p0_ack, p1_ack}, 32'd0);
        chk("rst_rdata", {16'd0, p0_rdata, p1_rdata}, 32'd0);
        chk("rst_addr",  {20'd0, a_addr}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // port 0 write then read, STROBE_CYCLES=1
        acc_a(0, 1'b1, 12'h123, 8'h5A, lat);
        chk("wr_lat", lat, 3);
        acc_a(0, 1'b0, 12'h123, 8'h00, lat);
        chk("rd_lat", lat, 3);
        chk("rd_data", {24'd0, p0_rdata}, 32'h5A);
        chk("rd_p1_untouched", {24'd0, p1_rdata}, 32'h00);

        // simultaneous requests straight after reset: 0,1,0,1 every 4 cycles
        do_reset();
        @(negedge clk);
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 12'h010; p0_wdata = 8'h11;
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 12'h020; p1_wdata = 8'h22;
        nacks = 0;
        for (int i = 1; i <= 40 && nacks < 4; i++) begin
            @(negedge clk);
            if (p0_ack && p1_ack) chk("tie_both_ack", 32'd1, 32'd0);
            if (p0_ack || p1_ack) begin
                ack_port[nacks] = p1_ack ? 1 : 0;
                ack_cyc[nacks]  = i;
                nacks++;
            end
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        chk("tie_nacks", nacks, 4);
        for (int k = 0; k < 4; k++) begin
            if (k < nacks) begin
                chk("tie_port", ack_port[k], k % 2);
                chk("tie_cycle", ack_cyc[k], 3 + 4 * k);
            end
        end

        // port 1 waits through a port 0 read; last grant was port 1 so port 0 goes first
        @(negedge clk);
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 12'h010;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 12'h020;
        p0_seen = 0;
        p1_seen = 0;
        for (int i = 1; i <= 30 && p1_seen == 0; i++) begin
            @(negedge clk);
            if (p0_ack) begin
                p0_seen = i;
                p0_req = 1'b0;
                chk("rr_p0_rdata", {24'd0, p0_rdata}, 32'h11);
                chk("rr_p1_ack_low", {31'd0, p1_ack}, 32'd0);
            end
            if (p1_ack) begin
                p1_seen = i;
                p1_req = 1'b0;
                chk("rr_p1_rdata", {24'd0, p1_rdata}, 32'h22);
                chk("rr_p0_rdata_kept", {24'd0, p0_rdata}, 32'h11);
                chk("rr_p0_ack_low", {31'd0, p0_ack}, 32'd0);
            end
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        chk("rr_p0_cycle", p0_seen, 3);
        chk("rr_p1_cycle", p1_seen, 7);

        // reset during the strobe of a write aborts it; held request is re-served
        @(negedge clk);
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 12'h030; p0_wdata = 8'h77;
        for (int i = 0; i < 10 && a_we_n; i++) @(negedge clk);
        chk("abort_in_strobe", {31'd0, a_we_n}, 32'd0);
        reset = 1'b1;
        #1;
        chk("abort_strobes", {29'd0, a_ce_n, a_we_n, a_oe_n}, 32'h7);
        chk("abort_no_ack", {30'd0, p0_ack, p1_ack}, 32'd0);
        chk("abort_busy", {31'd0, a_busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (p0_ack) begin
                lat = i;
                break;
            end
        end
        p0_req = 1'b0;
        chk("abort_reserve_lat", lat, 3);
        acc_a(0, 1'b0, 12'h030, 8'h00, lat);
        chk("abort_readback", {24'd0, p0_rdata}, 32'h77);

        // STROBE_CYCLES=4 at the top address
        acc_b(1'b1, 12'hFFF, 8'hA5, lat, low);
        chk("s4_wr_lat", lat, 6);
        chk("s4_we_low_cycles", low, 4);
        acc_b(1'b0, 12'hFFF, 8'h00, lat, low);
        chk("s4_rd_lat", lat, 6);
        chk("s4_oe_low_cycles", low, 4);
        chk("s4_rd_data", {24'd0, b_rdata}, 32'hA5);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", n_pass, n_chk);
        $fatal(1);
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SRAM and port data width.
REQ-002 Parameter ADDR_WIDTH, default 12, SRAM and port address width (4096 words).
REQ-003 Parameter STROBE_CYCLES, default 1, cycles WE/OE held active; legal range 1..15.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 p0_req / p1_req  input  1  access request from port 0/1, level, held until ack.
REQ-007 p0_we / p1_we  input  1  1 = write, 0 = read; stable while req high.
REQ-008 p0_addr / p1_addr  input  ADDR_WIDTH  word address; stable while req high.
REQ-009 p0_wdata / p1_wdata  input  DATA_WIDTH  write data; stable while req high.
REQ-010 p0_ack / p1_ack  output  1  one-cycle completion pulse.
REQ-011 p0_rdata / p1_rdata  output  DATA_WIDTH  registered read data, valid with ack, held until next read on that port.
REQ-012 sram_addr  output  ADDR_WIDTH  SRAM address.
REQ-013 sram_data  inout  DATA_WIDTH  SRAM data bus; driven only during write cycles, else high-Z.
REQ-014 sram_ce_n / sram_we_n / sram_oe_n  output  1  active-low chip, write and output enables.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states SHALL be IDLE, SETUP, STROBE, HOLD.
REQ-017 IDLE: ce_n=we_n=oe_n=1, bus released; if any req high, latch winner's addr/we/wdata, record grant, go to SETUP.
REQ-018 Arbitration SHALL be round-robin: single requester wins; both high -> port not granted last; last_grant resets to port 1, so port 0 wins first tie.
REQ-019 SETUP (1 cycle): ce_n=0, sram_addr = latched address, we_n=oe_n=1; write drives sram_data with latched wdata.
REQ-020 STROBE (STROBE_CYCLES cycles, counter-timed): ce_n=0; write: we_n=0 and data driven; read: oe_n=0, bus released.
REQ-021 Read data SHALL be captured from sram_data into the granted port's rdata on the rising edge that ends the last STROBE cycle.
REQ-022 HOLD (1 cycle): ce_n=0, we_n=oe_n=1, address unchanged; write data still driven; granted port's ack=1; then IDLE.
REQ-023 Latency: req sampled in IDLE at edge N -> ack high during cycle N+STROBE_CYCLES+2; back-to-back access period STROBE_CYCLES+3 cycles.
REQ-024 Requester SHALL drop req on the edge where ack is seen; req still high in IDLE is a new request.
REQ-025 Requests arriving while busy SHALL wait; no request is dropped or reordered within a port.
REQ-026 we_n and oe_n SHALL never be low together; sram_data SHALL never be driven while oe_n=0.
REQ-027 sram_addr and latched write data SHALL be constant from SETUP through HOLD inclusive.
REQ-028 Non-granted port's ack SHALL stay 0 and its rdata unchanged.
REQ-029 Port inputs changing while busy SHALL not affect the access in progress.

Reset
REQ-030 Reset SHALL asynchronously force IDLE, ce_n=we_n=oe_n=1, sram_data high-Z, acks 0, busy 0, rdata 0, sram_addr 0, strobe counter 0, last_grant=1.
REQ-031 Reset mid-access SHALL abort it immediately with no ack; after release the FSM re-arbitrates held requests from IDLE.

Verification
REQ-032 Bench SHALL pair the block with the project's asynchronous SRAM model and assertions for REQ-026/027.
REQ-033 Port 0 write 0x5A to 0x123, then port 0 read 0x123 -> p0_ack 3 cycles after each sampled req (STROBE_CYCLES=1), p0_rdata=0x5A.
REQ-034 p0_req and p1_req rise same cycle after reset -> port 0 served first, port 1 next, alternating while both held.
REQ-035 Port 1 holds req during port 0 access -> port 1 SETUP starts the cycle after port 0 HOLD+IDLE; p0_rdata unaffected by port 1 read.
REQ-036 STROBE_CYCLES=4 write/read 0xA5 at 0xFFF -> we_n/oe_n low exactly 4 cycles, ack 6 cycles after sample, rdata=0xA5.
REQ-037 Reset asserted in STROBE of a write -> all strobes high and bus high-Z same cycle, no ack; held req re-served after release.
